// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared MDU opcodes and default latencies
package mult_div_unit_pkg;
    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result and divide-by-zero flag
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [63:0] res,
    output logic        div0
);
    logic        sdiv;
    logic [31:0] ma, mb, mb_nz, q, r, qs, rs;
    logic [63:0] pu, ps;
    // one unsigned divider serves both divides by working on magnitudes
    always_comb begin
        sdiv  = op == MDU_DIV;
        ma    = (sdiv && a[31]) ? -a : a;
        mb    = (sdiv && b[31]) ? -b : b;
        mb_nz = (mb == 32'd0) ? 32'd1 : mb;
        q     = ma / mb_nz;
        r     = ma % mb_nz;
        qs    = (sdiv && (a[31] ^ b[31])) ? -q : q;
        rs    = (sdiv && a[31]) ? -r : r;
        pu    = {32'd0, a} * {32'd0, b};
        ps    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res   = (op == MDU_MULTU) ? pu : (op == MDU_MULT) ? ps : {rs, qs};
        div0  = op[1] && (b == 32'd0);
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/div unit owning the HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  MDUOp,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        Cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    logic [CW-1:0] cnt;
    logic [31:0]   phi, plo;
    logic          pdiv0, div0;
    logic [63:0]   res;
    mdu_arith u_arith (.a(A), .b(B), .op(MDUOp), .res(res), .div0(div0));
    assign Busy = cnt != '0;
    // counter, pending result and HI/LO; Start wins over mthi/mtlo, RUN ignores both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phi   <= '0;
            plo   <= '0;
            pdiv0 <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else if (Busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && !pdiv0) begin
                HI <= phi;
                LO <= plo;
            end
        end else if (!Cancel) begin
            if (Start) begin
                cnt        <= MDUOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                {phi, plo} <= res;
                pdiv0      <= div0;
            end else begin
                if (HIWrite) HI <= A;
                if (LOWrite) LO <= A;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed corner cases plus random ops against a behavioural model
module tb_mult_div_unit;
    logic        clk = 1'b0, reset = 1'b1, Start = 1'b0, HIWrite = 1'b0, LOWrite = 1'b0, Cancel = 1'b0;
    logic [1:0]  MDUOp = 2'b00;
    logic [31:0] A = '0, B = '0;
    logic        Busy;
    logic [31:0] HI, LO;
    logic [31:0] mhi = '0, mlo = '0;
    int          vectors = 0, miscompares = 0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .HIWrite(HIWrite),
        .LOWrite(LOWrite), .Cancel(Cancel), .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint q, r;
        longint unsigned uq, ur;
        if (op == 2'b00) return ua * ub;
        if (op == 2'b01) return sa * sb;
        if (op == 2'b10) begin
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // called at a negedge; returns at the negedge right after Busy must have fallen
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_start, input int inj_hi);
        logic [63:0] r;
        int n;
        n = op[1] ? 10 : 5;
        Start = 1'b1; MDUOp = op; A = a; B = b;
        check("busy_in_start_cycle", {63'd0, Busy}, 64'd0);
        @(negedge clk);
        Start = 1'b0; A = $urandom; B = $urandom;
        for (int i = 0; i < n; i++) begin
            check("busy_run", {63'd0, Busy}, 64'd1);
            check("hilo_hold_run", {HI, LO}, {mhi, mlo});
            Start = (i == inj_start);
            MDUOp = 2'b01;
            if (i == inj_start) begin A = 32'd2; B = 32'd2; end
            HIWrite = (i == inj_hi);
            if (i == inj_hi) A = 32'hAAAA;
            @(negedge clk);
            Start = 1'b0; HIWrite = 1'b0;
        end
        if (b != 32'd0 || !op[1]) begin
            r = model(op, a, b);
            {mhi, mlo} = r;
        end
        check("busy_done", {63'd0, Busy}, 64'd0);
        check("hi_result", {32'd0, HI}, {32'd0, mhi});
        check("lo_result", {32'd0, LO}, {32'd0, mlo});
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] v, input logic cancel);
        HIWrite = hw; LOWrite = lw; A = v; Cancel = cancel;
        @(negedge clk);
        HIWrite = 1'b0; LOWrite = 1'b0; Cancel = 1'b0;
        if (!cancel && hw) mhi = v;
        if (!cancel && lw) mlo = v;
        check("mt_hilo", {HI, LO}, {mhi, mlo});
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_busy", {63'd0, Busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_hilo", {HI, LO}, 64'd0);
        do_op(2'b01, 32'hFFFFFFFE, 32'd3, -1, -1);
        check("mult_neg_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
        do_op(2'b10, 32'd100, 32'd7, 4, -1);
        check("divu_const", {HI, LO}, {32'd2, 32'd14});
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, -1, -1);
        check("div_neg_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, -1, -1);
        check("div_ovf_const", {HI, LO}, 64'h00000000_80000000);
        mt(1'b1, 1'b0, 32'h1234, 1'b0);
        mt(1'b0, 1'b1, 32'h5678, 1'b0);
        do_op(2'b11, 32'd5, 32'd0, -1, -1);
        check("div0_const", {HI, LO}, 64'h00001234_00005678);
        Start = 1'b1; Cancel = 1'b1; MDUOp = 2'b00; A = 32'd9; B = 32'd9;
        @(negedge clk);
        Start = 1'b0; Cancel = 1'b0;
        check("cancel_busy", {63'd0, Busy}, 64'd0);
        check("cancel_hilo", {HI, LO}, {mhi, mlo});
        mt(1'b1, 1'b1, 32'hDEAD, 1'b1);
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 2);
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
        check("multu_max_const", {HI, LO}, 64'hFFFFFFFE_00000001);
        Start = 1'b1; MDUOp = 2'b11; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy", {63'd0, Busy}, 64'd0);
        check("async_reset_hilo", {HI, LO}, 64'd0);
        mhi = '0; mlo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("no_commit_after_reset", {HI, LO}, 64'd0);
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) mt(1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            do_op(2'($urandom), ra, rb, ($urandom_range(0, 1) ? $urandom_range(0, 4) : -1),
                  ($urandom_range(0, 1) ? $urandom_range(0, 4) : -1));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
